bridge_byte_scheduler: RTL and testbench
========================================

# bridge_byte_scheduler

Schedules the loader's byte-wide memory write port. Bridge word writes are buffered in a small FIFO and serialised MSB-first into four byte writes with `mem_ready` backpressure, so back-to-back bridge writes are never lost. A second byte-wide requester (CPU/debug side) shares the same memory port under round-robin arbitration at word boundaries. The block sits between the APF bridge and the target memory in the loader path.

## Interface
- `VALID_BITS`, default `'1`: address window mask. A bridge write is accepted only if `(bridge_addr & ~VALID_BITS) == 0`.
- `FIFO_DEPTH`, default `4`: word FIFO depth. Power of two, minimum 2.

- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `bridge_addr` in 32: byte address of the word.
- `bridge_wr_data` in 32: word data; byte `[31:24]` is written first.
- `bridge_wr` in 1: one-cycle write strobe.
- `cpu_req` in 1: byte request. Held with `cpu_addr` and `cpu_data` stable until granted.
- `cpu_addr` in 32: CPU byte address.
- `cpu_data` in 8: CPU byte data.
- `cpu_grant` out 1: pulses in the cycle the CPU byte is accepted by memory.
- `mem_address` out 32: memory byte address.
- `mem_data` out 8: memory byte data.
- `mem_wr` out 1: write request. Held until `mem_ready`.
- `mem_ready` in 1: memory accepts the write when `mem_wr && mem_ready`.
- `busy` out 1: FIFO non-empty or FSM not in IDLE.
- `overflow` out 1: sticky. Set when a valid bridge write is dropped. Cleared only by reset.

## Operation
- **FIFO push**
  - Each valid `bridge_wr` pushes `{addr, data}`.
  - A push when the FIFO is full is allowed only if a pop happens in the same cycle.
  - Otherwise the word is dropped and `overflow` is set.
  - Writes to an invalid address are ignored silently and do not set `overflow`.
- **FSM states:** IDLE, LOADER, CPU.
- **Decision point:** IDLE, or completion of the last transfer in LOADER or CPU.
  - Candidates are "FIFO non-empty" and `cpu_req`.
  - If both are pending, pick the one not served last (`last_owner` register, reset value = CPU, so the loader wins first).
  - If only one is pending, pick it. If neither, go to IDLE.
- **LOADER**
  - Pop one entry and load the address, data shift register and `lane` counter = 0.
  - Byte `k` is written at `addr + k` with data `word[31-8k -: 8]`.
  - `lane` advances only on `mem_wr && mem_ready`.
  - The four bytes of a word are never interleaved with CPU bytes.
- **CPU**
  - Present `cpu_addr`/`cpu_data` with `mem_wr` high.
  - On `mem_ready`, pulse `cpu_grant`. Exactly one byte per grant.
- **Address arithmetic:** modulo 2^32. A word at `32'hFFFF_FFFE` writes bytes at FFFE, FFFF, 0000, 0001.
- **Output stability:** `mem_address`, `mem_data` and `mem_wr` are registered and must not change while `mem_wr && !mem_ready`.

## Timing
- **Reset values:** `mem_wr`=0, `mem_address`=0, `mem_data`=0, `cpu_grant`=0, `busy`=0, `overflow`=0. FIFO empty, state IDLE.
- **Latency:** `bridge_wr` sampled at edge E0 (FIFO empty, FSM IDLE) gives `mem_wr` high after E1, carrying the first byte.
- **CPU latency:** `cpu_req` rising before edge E0 in IDLE gives `mem_wr` high after E0.
- **Throughput:** with `mem_ready` held high, one byte per cycle. Consecutive words stream with zero bubble, because the decision happens on the cycle the 4th byte is accepted.
- **Grant timing:** `cpu_grant` is combinational, equal to `state==CPU && mem_ready`. The requester may drop `cpu_req` on the following cycle.
- **Backpressure:** `mem_ready` low stalls the FSM indefinitely; FIFO pushes continue until the FIFO is full.
- **Reset mid-operation:** the in-flight word and FIFO contents are discarded. `mem_wr` is low after the reset edge. A pending CPU request is re-arbitrated afterwards.
- **Simultaneous events:** a push and a pop in the same cycle with the FIFO full are both performed, and occupancy is unchanged.

## Structure
- **Package `loader_pkg`:**
  - state enum `sched_state_e` {IDLE, LOADER, CPU}
  - `BYTES_PER_WORD = 4`
  - typedef `bridge_word_t` struct {addr[31:0], data[31:0]}
- **Sub-module `word_fifo`:** synchronous FIFO parameterised on depth and `bridge_word_t`.
  - Signals: push, pop, full, empty.
  - Registered read data, valid in the same cycle `empty` is low (show-ahead).
- The top module holds the FSM, lane counter, shift register, `last_owner` and `overflow`.

## Test plan
- **Single word:** write `bridge_addr=0x100`, data `0xA1B2C3D4`, `mem_ready`=1 → bytes A1@100, B2@101, C3@102, D4@103 on 4 consecutive cycles. The first `mem_wr` appears 2 edges after the strobe.
- **Burst:** 4 back-to-back words with `FIFO_DEPTH`=4 → 16 contiguous byte writes with no gaps and `overflow`=0. A 6th word written while `mem_ready` is held low sets `overflow`.
- **Backpressure:** toggle `mem_ready` pseudo-randomly during a word → each byte is held stable until accepted, with no duplicates and no skips.
- **Arbitration:** `cpu_req` (`addr 0x20`, data `0x5A`) asserted mid-word while 2 words are queued → order is word0 (4 bytes), CPU 5A@20, word1. `cpu_grant` is a single pulse.
- **Invalid address and wrap:**
  - `VALID_BITS=32'h0000_FFFF`, write to `0x1_0000` → no memory writes, `overflow`=0.
  - Word at `0xFFFF_FFFE` → byte addresses FFFE, FFFF, 0, 1.
- **Mid-transfer reset:** assert `reset` after byte 1 → `mem_wr`=0 after the next edge, FIFO empty, `busy`=0, `overflow`=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the loader write path.
//   sched_state_e  : owner of the byte-wide memory port
//   BYTES_PER_WORD : bytes emitted per buffered bridge word
//   bridge_word_t  : one buffered bridge write {addr, data}
//   addr_in_window : true when an address lies inside the accepted window
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADER = 2'd1,
        CPU    = 2'd2
    } sched_state_e;

    localparam int BYTES_PER_WORD = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } bridge_word_t;

    function automatic logic addr_in_window(input logic [31:0] addr, input logic [31:0] mask);
        return ((addr & ~mask) == 32'h0000_0000);
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous show-ahead FIFO for buffered bridge words.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   push, push_data : write an entry (ignored when full unless a pop happens in the same cycle)
//   pop             : consume the head entry (ignored when empty)
//   rd_data         : head entry, taken from storage flops, valid whenever empty is low
//   full, empty     : occupancy flags
module word_fifo
    import loader_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = bridge_word_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     rd_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    T                 mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign do_pop_s  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push_s = push && (!full || do_pop_s);
    assign rd_data   = mem_r[rd_ptr_r];

    // Entry storage; contents are only observed through the occupancy-gated head.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy count; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bridge_byte_scheduler.sv
// Byte-wide memory write scheduler for the loader path.
// Bridge word writes are queued and emitted MSB-first as four byte writes;
// a CPU/debug byte requester shares the port, arbitrated round-robin at word boundaries.
// Ports:
//   clk, reset                               : clock, synchronous active-high reset
//   bridge_addr, bridge_wr_data, bridge_wr   : bridge word write (one-cycle strobe)
//   cpu_req, cpu_addr, cpu_data, cpu_grant   : CPU byte request / grant pulse
//   mem_address, mem_data, mem_wr, mem_ready : registered byte write port with backpressure
//   busy                                     : work queued or in flight
//   overflow                                 : sticky, a valid bridge word was dropped
module bridge_byte_scheduler
    import loader_pkg::*;
#(
    parameter logic [31:0] VALID_BITS = 32'hFFFF_FFFF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bridge_addr,
    input  logic [31:0] bridge_wr_data,
    input  logic        bridge_wr,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    output logic        cpu_grant,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_data,
    output logic        mem_wr,
    input  logic        mem_ready,
    output logic        busy,
    output logic        overflow
);

    localparam int         SHIFT_W   = 8 * (BYTES_PER_WORD - 1);
    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    sched_state_e       state_r, state_nxt_s;
    sched_state_e       last_owner_r, last_owner_nxt_s;
    sched_state_e       pick_s;
    logic [1:0]         lane_r, lane_nxt_s;
    logic [SHIFT_W-1:0] shift_r, shift_nxt_s;
    logic [31:0]        mem_address_r, mem_address_nxt_s;
    logic [7:0]         mem_data_r, mem_data_nxt_s;
    logic               mem_wr_r, mem_wr_nxt_s;
    logic               overflow_r;

    bridge_word_t       push_word_s;
    bridge_word_t       head_word_s;
    logic               bridge_valid_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               pop_s;
    logic               decide_s;
    logic               cpu_pend_s;

    assign bridge_valid_s = bridge_wr && addr_in_window(bridge_addr, VALID_BITS);
    assign push_word_s    = '{addr: bridge_addr, data: bridge_wr_data};

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (bridge_word_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bridge_valid_s),
        .push_data (push_word_s),
        .pop       (pop_s),
        .rd_data   (head_word_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // The CPU request is still high in the cycle its byte completes, so it is
    // not a candidate again until the requester has had a chance to drop it.
    assign cpu_pend_s = cpu_req && (state_r != CPU);

    // Decision point and round-robin choice between queued words and the CPU.
    always_comb begin
        decide_s = 1'b0;
        pick_s   = IDLE;
        case (state_r)
            IDLE:    decide_s = 1'b1;
            LOADER:  decide_s = mem_ready && (lane_r == LAST_LANE);
            CPU:     decide_s = mem_ready;
            default: decide_s = 1'b1;
        endcase
        if (!fifo_empty_s && cpu_pend_s) begin
            pick_s = (last_owner_r == CPU) ? LOADER : CPU;
        end else if (!fifo_empty_s) begin
            pick_s = LOADER;
        end else if (cpu_pend_s) begin
            pick_s = CPU;
        end else begin
            pick_s = IDLE;
        end
    end

    // Next-state and next-output logic; outputs hold unless a byte is accepted.
    always_comb begin
        state_nxt_s       = state_r;
        last_owner_nxt_s  = last_owner_r;
        lane_nxt_s        = lane_r;
        shift_nxt_s       = shift_r;
        mem_address_nxt_s = mem_address_r;
        mem_data_nxt_s    = mem_data_r;
        mem_wr_nxt_s      = mem_wr_r;
        pop_s             = 1'b0;
        if (decide_s) begin
            state_nxt_s = pick_s;
            case (pick_s)
                LOADER: begin
                    pop_s             = 1'b1;
                    last_owner_nxt_s  = LOADER;
                    lane_nxt_s        = 2'd0;
                    mem_address_nxt_s = head_word_s.addr;
                    mem_data_nxt_s    = head_word_s.data[31:24];
                    shift_nxt_s       = head_word_s.data[SHIFT_W-1:0];
                    mem_wr_nxt_s      = 1'b1;
                end
                CPU: begin
                    last_owner_nxt_s  = CPU;
                    mem_address_nxt_s = cpu_addr;
                    mem_data_nxt_s    = cpu_data;
                    mem_wr_nxt_s      = 1'b1;
                end
                default: begin
                    mem_wr_nxt_s = 1'b0;
                end
            endcase
        end else if ((state_r == LOADER) && mem_ready) begin
            // Address increments modulo 2^32, so words straddling the top wrap to zero.
            lane_nxt_s        = lane_r + 2'd1;
            mem_address_nxt_s = mem_address_r + 32'd1;
            mem_data_nxt_s    = shift_r[SHIFT_W-1 -: 8];
            shift_nxt_s       = {shift_r[SHIFT_W-9:0], 8'h00};
        end else begin
            mem_wr_nxt_s = mem_wr_r;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            last_owner_r  <= CPU;
            lane_r        <= 2'd0;
            shift_r       <= SHIFT_W'(0);
            mem_address_r <= 32'h0000_0000;
            mem_data_r    <= 8'h00;
            mem_wr_r      <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            last_owner_r  <= last_owner_nxt_s;
            lane_r        <= lane_nxt_s;
            shift_r       <= shift_nxt_s;
            mem_address_r <= mem_address_nxt_s;
            mem_data_r    <= mem_data_nxt_s;
            mem_wr_r      <= mem_wr_nxt_s;
        end
    end

    // Sticky drop flag: a valid word arrived while full with no pop to make room.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | (bridge_valid_s && fifo_full_s && !pop_s);
        end
    end

    assign mem_address = mem_address_r;
    assign mem_data    = mem_data_r;
    assign mem_wr      = mem_wr_r;
    assign overflow    = overflow_r;
    assign cpu_grant   = (state_r == CPU) && mem_ready;
    assign busy        = !fifo_empty_s || (state_r != IDLE);

endmodule

// File: tb/tb_bridge_byte_scheduler.sv
// Scoreboard bench for bridge_byte_scheduler: stimulus pushes expected byte
// writes into a queue, a negedge monitor pops and compares each accepted byte.
module tb_bridge_byte_scheduler;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        logic        is_cpu;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bridge_addr;
    logic [31:0] bridge_wr_data;
    logic        bridge_wr;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        mem_ready;
    logic        mem_ready2;

    logic        cpu_grant, mem_wr, busy, overflow;
    logic [31:0] mem_address;
    logic [7:0]  mem_data;
    logic        d2_cpu_grant, d2_mem_wr, d2_busy, d2_overflow;
    logic [31:0] d2_mem_address;
    logic [7:0]  d2_mem_data;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    int   acc_first = 0;
    int   acc_last  = 0;
    int   grant_cnt = 0;
    int   d2_wr_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    bridge_byte_scheduler dut (
        .clk(clk), .reset(reset),
        .bridge_addr(bridge_addr), .bridge_wr_data(bridge_wr_data), .bridge_wr(bridge_wr),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_grant(cpu_grant),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wr(mem_wr), .mem_ready(mem_ready),
        .busy(busy), .overflow(overflow)
    );

    bridge_byte_scheduler #(.VALID_BITS(32'h0000_FFFF), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset),
        .bridge_addr(bridge_addr), .bridge_wr_data(bridge_wr_data), .bridge_wr(bridge_wr),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_grant(d2_cpu_grant),
        .mem_address(d2_mem_address), .mem_data(d2_mem_data), .mem_wr(d2_mem_wr), .mem_ready(mem_ready2),
        .busy(d2_busy), .overflow(d2_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: compare accepted bytes, grant pulses and stall stability.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_addr;
        logic [7:0]  prev_data;
        exp_t        e;
        prev_stall = 1'b0;
        prev_addr  = 32'h0;
        prev_data  = 8'h0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_wr", {31'h0, mem_wr}, 32'h1);
                    chk("hold_addr", mem_address, prev_addr);
                    chk("hold_data", {24'h0, mem_data}, {24'h0, prev_data});
                end
                if (mem_wr && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual=%0h:%0h required=none", mem_address, mem_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte_addr", mem_address, e.addr);
                        chk("byte_data", {24'h0, mem_data}, {24'h0, e.data});
                        chk("grant_owner", {31'h0, cpu_grant}, {31'h0, e.is_cpu});
                    end
                    if (acc_cnt == 0) acc_first = cyc;
                    acc_last = cyc;
                    acc_cnt++;
                end else begin
                    chk("grant_idle", {31'h0, cpu_grant}, 32'h0);
                end
                if (cpu_grant) grant_cnt++;
                if (d2_mem_wr) d2_wr_cnt++;
                prev_stall = mem_wr && !mem_ready;
                prev_addr  = mem_address;
                prev_data  = mem_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk("queue_empty_before_reset", exp_q.size(), 32'h0);
        exp_q.delete();
        reset = 1'b1; bridge_wr = 1'b0; cpu_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic bridge_write(input logic [31:0] a, input logic [31:0] d);
        bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
        tick();
        bridge_wr = 1'b0;
    endtask

    task automatic push_byte(input logic [31:0] a, input logic [7:0] d, input logic is_cpu);
        exp_t e;
        e.addr = a; e.data = d; e.is_cpu = is_cpu;
        exp_q.push_back(e);
    endtask

    task automatic push_word(input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) push_byte(a + 32'(k), d[31-8*k -: 8], 1'b0);
    endtask

    task automatic wait_drain(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_timeout", exp_q.size(), 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] burst_d [4];
        logic [15:0] pat;
        logic        got;
        burst_d[0] = 32'h0011_2233; burst_d[1] = 32'h4455_6677;
        burst_d[2] = 32'h8899_AABB; burst_d[3] = 32'hCCDD_EEFF;
        pat = 16'b1001_0110_0100_1100;
        reset = 1'b1; bridge_wr = 1'b0; bridge_addr = 32'h0; bridge_wr_data = 32'h0;
        cpu_req = 1'b0; cpu_addr = 32'h0; cpu_data = 8'h0; mem_ready = 1'b1; mem_ready2 = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Reset values
        chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_data", {24'h0, mem_data}, 32'h0);
        chk("rst_cpu_grant", {31'h0, cpu_grant}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_overflow", {31'h0, overflow}, 32'h0);

        // Single word, latency and four consecutive bytes
        acc_cnt = 0;
        push_word(32'h0000_0100, 32'hA1B2_C3D4);
        bridge_write(32'h0000_0100, 32'hA1B2_C3D4);
        chk("lat_e0_mem_wr", {31'h0, mem_wr}, 32'h0);
        chk("lat_e0_busy", {31'h0, busy}, 32'h1);
        tick();
        chk("lat_e1_mem_wr", {31'h0, mem_wr}, 32'h1);
        chk("lat_e1_addr", mem_address, 32'h0000_0100);
        chk("lat_e1_data", {24'h0, mem_data}, 32'hA1);
        wait_drain(20);
        chk("single_count", acc_cnt, 32'd4);
        chk("single_span", acc_last - acc_first, 32'd3);
        tick(); tick();
        chk("single_busy_done", {31'h0, busy}, 32'h0);

        // Burst of four words, no gaps
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) push_word(32'h0000_0200 + 32'(4*i), burst_d[i]);
        for (int i = 0; i < 4; i++) bridge_write(32'h0000_0200 + 32'(4*i), burst_d[i]);
        wait_drain(40);
        chk("burst_count", acc_cnt, 32'd16);
        chk("burst_span", acc_last - acc_first, 32'd15);
        chk("burst_overflow", {31'h0, overflow}, 32'h0);

        // Overflow: six words with memory stalled, the sixth is dropped
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) push_word(32'h0000_0300 + 32'(4*i), 32'h5000_0000 + 32'(i));
            bridge_write(32'h0000_0300 + 32'(4*i), 32'h5000_0000 + 32'(i));
            if (i == 4) chk("ovf_before_sixth", {31'h0, overflow}, 32'h0);
            if (i == 5) chk("ovf_after_sixth", {31'h0, overflow}, 32'h1);
        end
        mem_ready = 1'b1;
        wait_drain(60);
        chk("ovf_sticky", {31'h0, overflow}, 32'h1);
        do_reset();
        chk("ovf_cleared", {31'h0, overflow}, 32'h0);

        // Backpressure pattern during one word
        acc_cnt = 0;
        push_word(32'h0000_0600, 32'h1122_3344);
        bridge_write(32'h0000_0600, 32'h1122_3344);
        for (int i = 0; i < 40; i++) begin
            mem_ready = (i < 16) ? pat[i] : 1'b1;
            if (exp_q.size() == 0) break;
            tick();
        end
        mem_ready = 1'b1;
        chk("bp_drained", exp_q.size(), 32'h0);
        chk("bp_count", acc_cnt, 32'd4);

        // Arbitration: word0, CPU byte, word1
        do_reset();
        grant_cnt = 0;
        push_word(32'h0000_0400, 32'h0102_0304);
        push_byte(32'h0000_0020, 8'h5A, 1'b1);
        push_word(32'h0000_0410, 32'h0506_0708);
        bridge_write(32'h0000_0400, 32'h0102_0304);
        bridge_write(32'h0000_0410, 32'h0506_0708);
        tick();
        cpu_addr = 32'h0000_0020; cpu_data = 8'h5A; cpu_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_grant) begin
                got = 1'b1;
                break;
            end
        end
        chk("arb_grant_seen", {31'h0, got}, 32'h1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        wait_drain(30);
        chk("arb_grant_pulses", grant_cnt, 32'd1);

        // Invalid address window (second instance) and address wrap
        d2_wr_cnt = 0;
        push_word(32'h0001_0000, 32'hCAFE_BABE);
        bridge_write(32'h0001_0000, 32'hCAFE_BABE);
        push_byte(32'hFFFF_FFFE, 8'h88, 1'b0);
        push_byte(32'hFFFF_FFFF, 8'h99, 1'b0);
        push_byte(32'h0000_0000, 8'hAA, 1'b0);
        push_byte(32'h0000_0001, 8'hBB, 1'b0);
        bridge_write(32'hFFFF_FFFE, 32'h8899_AABB);
        wait_drain(30);
        tick(); tick();
        chk("inv_no_writes", d2_wr_cnt, 32'd0);
        chk("inv_overflow", {31'h0, d2_overflow}, 32'h0);
        chk("inv_busy", {31'h0, d2_busy}, 32'h0);
        chk("inv_grant", {31'h0, d2_cpu_grant}, 32'h0);

        // Reset after the first byte of a word with another word queued
        push_byte(32'h0000_0500, 8'hDE, 1'b0);
        bridge_write(32'h0000_0500, 32'hDEAD_BEEF);
        bridge_write(32'h0000_0504, 32'h0123_4567);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_mem_wr", {31'h0, mem_wr}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_overflow", {31'h0, overflow}, 32'h0);
        chk("midrst_queue", exp_q.size(), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("postrst_mem_wr", {31'h0, mem_wr}, 32'h0);
        chk("postrst_busy", {31'h0, busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
